// File: rtl/load_store_unit_if.sv
// Request, data-bus and response signals of the load/store unit.
// Signal suffixes are relative to the LSU: _i is driven into it, _o is driven by it.
interface load_store_unit_if #(
    parameter int unsigned C_XLEN = 32
) ();
    // Request from decode/ALU
    logic              req_valid_i;
    logic              req_ready_o;
    logic [C_XLEN-1:0] req_addr_i;
    logic [C_XLEN-1:0] req_wdata_i;
    logic              req_store_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    // Data bus
    logic              dbus_req_o;
    logic              dbus_we_o;
    logic [C_XLEN-1:0] dbus_addr_o;
    logic [3:0]        dbus_be_o;
    logic [C_XLEN-1:0] dbus_wdata_o;
    logic              dbus_ack_i;
    logic              dbus_err_i;
    logic [C_XLEN-1:0] dbus_rdata_i;
    // Response to writeback
    logic              rsp_valid_o;
    logic [C_XLEN-1:0] rsp_data_o;
    logic              rsp_misalign_o;
    logic              rsp_err_o;

    // LSU side
    modport master (
        input  req_valid_i, req_addr_i, req_wdata_i, req_store_i, req_size_i, req_unsigned_i,
        input  dbus_ack_i, dbus_err_i, dbus_rdata_i,
        output req_ready_o,
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        output rsp_valid_o, rsp_data_o, rsp_misalign_o, rsp_err_o
    );

    // Pipeline and memory side
    modport slave (
        output req_valid_i, req_addr_i, req_wdata_i, req_store_i, req_size_i, req_unsigned_i,
        output dbus_ack_i, dbus_err_i, dbus_rdata_i,
        input  req_ready_o,
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
        input  rsp_valid_o, rsp_data_o, rsp_misalign_o, rsp_err_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one data-bus transaction per request, load data aligned and
// extended for writeback, misaligned accesses and bus errors reported in the response.
module load_store_unit #(
    parameter int unsigned C_XLEN = 32
) (
    input  logic               clk_i,
    input  logic               resetb_i,
    input  logic               clk_en_i,
    load_store_unit_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [C_XLEN-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [C_XLEN-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              unsigned_q, unsigned_d;
    logic [C_XLEN-1:0] rsp_data_q, rsp_data_d;
    logic              misalign_q, misalign_d;
    logic              err_q, err_d;

    logic              accept;
    logic [1:0]        req_off;
    logic              req_misalign;
    logic [3:0]        req_be;
    logic [C_XLEN-1:0] req_wdata;
    logic [C_XLEN-1:0] rdata_shifted;
    logic [C_XLEN-1:0] load_data;

    assign accept  = (state_q == StIdle) && bus.req_valid_i && clk_en_i;
    assign req_off = bus.req_addr_i[1:0];

    // Decode the incoming request: alignment, byte lanes and lane-replicated store data
    always_comb begin
        req_misalign = 1'b1;
        req_be       = 4'b1111;
        req_wdata    = bus.req_wdata_i;
        unique case (bus.req_size_i)
            2'd0: begin
                req_misalign = 1'b0;
                req_be       = 4'b0001 << req_off;
                req_wdata    = {4{bus.req_wdata_i[7:0]}};
            end
            2'd1: begin
                req_misalign = req_off[0];
                req_be       = 4'b0011 << {req_off[1], 1'b0};
                req_wdata    = {2{bus.req_wdata_i[15:0]}};
            end
            2'd2: begin
                req_misalign = (req_off != 2'd0);
            end
            default: begin
                req_misalign = 1'b1;
            end
        endcase
    end

    assign rdata_shifted = bus.dbus_rdata_i >> {off_q, 3'b000};

    // Align and extend returned load data
    always_comb begin
        load_data = rdata_shifted;
        unique case (size_q)
            2'd0: load_data = unsigned_q ? {{(C_XLEN-8){1'b0}}, rdata_shifted[7:0]}
                                         : {{(C_XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'd1: load_data = unsigned_q ? {{(C_XLEN-16){1'b0}}, rdata_shifted[15:0]}
                                         : {{(C_XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    // FSM state register; async reset drops dbus_req_o at once
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the bus side advances regardless of clk_en_i
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = req_misalign ? StResp : StBusy;
            StBusy:  if (bus.dbus_ack_i) state_d = StResp;
            StResp:  if (clk_en_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.req_ready_o    = (state_q == StIdle);
        bus.dbus_req_o     = (state_q == StBusy);
        bus.rsp_valid_o    = (state_q == StResp);
        bus.dbus_we_o      = we_q;
        bus.dbus_addr_o    = addr_q;
        bus.dbus_be_o      = be_q;
        bus.dbus_wdata_o   = wdata_q;
        bus.rsp_data_o     = rsp_data_q;
        bus.rsp_misalign_o = misalign_q;
        bus.rsp_err_o      = err_q;
    end

    // Datapath next state: capture request on accept, capture response on ack
    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        off_d      = off_q;
        unsigned_d = unsigned_q;
        rsp_data_d = rsp_data_q;
        misalign_d = misalign_q;
        err_d      = err_q;
        if (accept) begin
            we_d       = bus.req_store_i;
            addr_d     = {bus.req_addr_i[C_XLEN-1:2], 2'b00};
            be_d       = req_be;
            wdata_d    = req_wdata;
            size_d     = bus.req_size_i;
            off_d      = req_off;
            unsigned_d = bus.req_unsigned_i;
            rsp_data_d = '0;
            misalign_d = req_misalign;
            err_d      = 1'b0;
        end else if ((state_q == StBusy) && bus.dbus_ack_i) begin
            err_d      = bus.dbus_err_i;
            rsp_data_d = (bus.dbus_err_i || we_q) ? '0 : load_data;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            off_q      <= '0;
            unsigned_q <= 1'b0;
            rsp_data_q <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            off_q      <= off_d;
            unsigned_q <= unsigned_d;
            rsp_data_q <= rsp_data_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
        end
    end

endmodule
